// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard control bundle between the WISC-15 datapath (master)
// and pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 4
);
  logic [REG_AW-1:0] id_rs1;
  logic              id_rs1_used;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs2_used;
  logic              id_halt;
  logic [REG_AW-1:0] ex_wb_dst;
  logic              ex_reg_wrt;
  logic              ex_mem_rd;
  logic              ex_redirect;
  logic              dm_busy;
  logic              pc_we;
  logic              if_id_we;
  logic              if_id_clr;
  logic              id_ex_we;
  logic              id_ex_clr;
  logic              ex_mem_we;
  logic              mem_wb_we;
  logic              mem_wb_clr;
  logic              hlt;

  modport master (
    output id_rs1, id_rs1_used, id_rs2, id_rs2_used,
    output id_halt, ex_wb_dst, ex_reg_wrt, ex_mem_rd,
    output ex_redirect, dm_busy,
    input  pc_we, if_id_we, if_id_clr, id_ex_we,
    input  id_ex_clr, ex_mem_we, mem_wb_we, mem_wb_clr,
    input  hlt
  );

  modport slave (
    input  id_rs1, id_rs1_used, id_rs2, id_rs2_used,
    input  id_halt, ex_wb_dst, ex_reg_wrt, ex_mem_rd,
    input  ex_redirect, dm_busy,
    output pc_we, if_id_we, if_id_clr, id_ex_we,
    output id_ex_clr, ex_mem_we, mem_wb_we, mem_wb_clr,
    output hlt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// WISC-15 pipeline control: stalls, flushes, memory freeze, halt drain.
// Optional PIPE_HAZARD_PERF_CNT_EN adds stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned REG_AW       = 4
) (
  input  logic clk,
  input  logic rst,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_e;

  localparam logic [REG_AW-1:0] R0 = '0;
  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hlt_q, hlt_d;

  logic pc_we, if_id_we, if_id_clr, id_ex_we;
  logic id_ex_clr, ex_mem_we, mem_wb_we, mem_wb_clr;
  logic load_use, rs1_hit, rs2_hit;

  assign rs1_hit = hz.id_rs1_used && (hz.id_rs1 == hz.ex_wb_dst);
  assign rs2_hit = hz.id_rs2_used && (hz.id_rs2 == hz.ex_wb_dst);
  assign load_use = hz.ex_mem_rd && hz.ex_reg_wrt &&
                    (hz.ex_wb_dst != R0) && (rs1_hit || rs2_hit);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_we      = 1'b1;
    if_id_we   = 1'b1;
    if_id_clr  = 1'b0;
    id_ex_we   = 1'b1;
    id_ex_clr  = 1'b0;
    ex_mem_we  = 1'b1;
    mem_wb_we  = 1'b1;
    mem_wb_clr = 1'b0;
    if (rst) begin
      pc_we      = 1'b0;
      if_id_we   = 1'b0;
      id_ex_we   = 1'b0;
      ex_mem_we  = 1'b0;
      mem_wb_we  = 1'b0;
      if_id_clr  = 1'b1;
      id_ex_clr  = 1'b1;
      mem_wb_clr = 1'b1;
    end else if (state_q == S_HALT) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (hz.dm_busy) begin
      // Freeze everything up to MEM; WB gets a bubble.
      pc_we      = 1'b0;
      if_id_we   = 1'b0;
      id_ex_we   = 1'b0;
      ex_mem_we  = 1'b0;
      mem_wb_clr = 1'b1;
    end else if (state_q == S_DRAIN) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_clr = 1'b1;
      if (cnt_q == 4'd0) begin
        state_d = S_HALT;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (hz.ex_redirect) begin
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
    end else if (load_use || hz.id_halt) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_clr = 1'b1;
      if (!load_use) begin
        state_d = S_DRAIN;
        cnt_d   = CNT_INIT;
      end
    end
  end

  assign hlt_d = (state_d == S_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= 4'd0;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hlt_q   <= hlt_d;
    end
  end

  assign hz.pc_we      = pc_we;
  assign hz.if_id_we   = if_id_we;
  assign hz.if_id_clr  = if_id_clr;
  assign hz.id_ex_we   = id_ex_we;
  assign hz.id_ex_clr  = id_ex_clr;
  assign hz.ex_mem_we  = ex_mem_we;
  assign hz.mem_wb_we  = mem_wb_we;
  assign hz.mem_wb_clr = mem_wb_clr;
  assign hz.hlt        = hlt_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [15:0] stall_q, stall_d, flush_q, flush_d;
  logic        stall_ev, flush_ev, in_run;

  // A redirect squashes a coincident load-use, so it is not a stall.
  assign in_run   = (state_q == S_RUN);
  assign stall_ev = in_run &&
                    (hz.dm_busy || (load_use && !hz.ex_redirect));
  assign flush_ev = in_run && hz.ex_redirect && !hz.dm_busy;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_ev && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if (flush_ev && (flush_q != 16'hFFFF)) begin
      flush_d = flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl against a
// behavioural model of the pipeline control rules.
module tb_pipe_hazard_ctrl;
  localparam int DC = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(AW)) bus ();

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  pipe_hazard_ctrl #(
    .DRAIN_CYCLES(DC),
    .REG_AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz(bus)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // model: 0 run, 1 drain, 2 halted
  int m_mode = 0;
  int m_left = 0;
  int m_hlt = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit hazard();
    bit h1, h2;
    h1 = bus.id_rs1_used && (bus.id_rs1 == bus.ex_wb_dst);
    h2 = bus.id_rs2_used && (bus.id_rs2 == bus.ex_wb_dst);
    return bus.ex_mem_rd && bus.ex_reg_wrt &&
           (bus.ex_wb_dst != 0) && (h1 || h2);
  endfunction

  // {pc_we,if_id_we,if_id_clr,id_ex_we,id_ex_clr,ex_mem_we,mem_wb_we,mem_wb_clr}
  function automatic logic [7:0] expect_ctl();
    bit lu;
    lu = hazard();
    if (rst) return 8'b0010_1001;
    if (m_mode == 2) return 8'b0000_0000;
    if (bus.dm_busy) return 8'b0000_0011;
    if (m_mode == 1) return 8'b0001_1110;
    if (bus.ex_redirect) return 8'b1111_1110;
    if (lu || bus.id_halt) return 8'b0001_1110;
    return 8'b1101_0110;
  endfunction

  task automatic compare_all();
    logic [7:0] act;
    act = {bus.pc_we, bus.if_id_we, bus.if_id_clr, bus.id_ex_we,
           bus.id_ex_clr, bus.ex_mem_we, bus.mem_wb_we, bus.mem_wb_clr};
    chk("ctl", int'(act), int'(expect_ctl()));
    chk("hlt", int'(bus.hlt), m_hlt);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("stall_cnt", int'(stall_cnt), m_stall);
    chk("flush_cnt", int'(flush_cnt), m_flush);
`endif
  endtask

  task automatic model_update();
    bit lu;
    lu = hazard();
    if (rst) begin
      m_mode = 0; m_left = 0; m_hlt = 0;
      m_stall = 0; m_flush = 0;
    end else if (m_mode == 0) begin
      if (bus.dm_busy) begin
        if (m_stall < 65535) m_stall++;
      end else if (bus.ex_redirect) begin
        if (m_flush < 65535) m_flush++;
      end else if (lu) begin
        if (m_stall < 65535) m_stall++;
      end else if (bus.id_halt) begin
        m_mode = 1;
        m_left = DC;
      end
    end else if (m_mode == 1 && !bus.dm_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 2;
        m_hlt = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_mode == 1) begin
      assert (!bus.ex_redirect) else begin
        errors++;
        $display("FAIL redirect_in_drain got 1 expected 0");
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.id_rs1 = '0; bus.id_rs1_used = 0;
    bus.id_rs2 = '0; bus.id_rs2_used = 0;
    bus.id_halt = 0; bus.ex_wb_dst = '0;
    bus.ex_reg_wrt = 0; bus.ex_mem_rd = 0;
    bus.ex_redirect = 0; bus.dm_busy = 0;
  endtask

  initial begin
    int n;
`ifdef PIPE_HAZARD_PERF_CNT_EN
    int s0, f0;
`endif
    rst = 1;
    idle();
    @(posedge clk);
    model_update();
    #1;
    chk("rst_pc_we", int'(bus.pc_we), 0);
    chk("rst_if_id_clr", int'(bus.if_id_clr), 1);
    chk("rst_mem_wb_clr", int'(bus.mem_wb_clr), 1);
    tick();
    rst = 0;
    #1;
    chk("run_pc_we", int'(bus.pc_we), 1);
    chk("run_hlt", int'(bus.hlt), 0);
    tick();

    // load-use on rs1
    bus.ex_mem_rd = 1; bus.ex_reg_wrt = 1; bus.ex_wb_dst = 3;
    bus.id_rs1 = 3; bus.id_rs1_used = 1;
    #1;
    chk("lu_pc_we", int'(bus.pc_we), 0);
    chk("lu_if_id_we", int'(bus.if_id_we), 0);
    chk("lu_id_ex_clr", int'(bus.id_ex_clr), 1);
    tick();
    bus.ex_mem_rd = 0;
    #1;
    chk("lu_next_pc_we", int'(bus.pc_we), 1);
    chk("lu_next_id_ex_clr", int'(bus.id_ex_clr), 0);
    tick();

    // R0 and unused source never hazard
    bus.ex_mem_rd = 1; bus.ex_wb_dst = 0; bus.id_rs1 = 0;
    #1;
    chk("r0_pc_we", int'(bus.pc_we), 1);
    chk("r0_id_ex_clr", int'(bus.id_ex_clr), 0);
    tick();
    bus.ex_wb_dst = 3; bus.id_rs1 = 3; bus.id_rs1_used = 0;
    #1;
    chk("unused_pc_we", int'(bus.pc_we), 1);
    chk("unused_id_ex_clr", int'(bus.id_ex_clr), 0);
    tick();

    // redirect beats load-use
    bus.id_rs1_used = 1; bus.ex_redirect = 1;
`ifdef PIPE_HAZARD_PERF_CNT_EN
    s0 = m_stall; f0 = m_flush;
`endif
    #1;
    chk("rd_pc_we", int'(bus.pc_we), 1);
    chk("rd_if_id_clr", int'(bus.if_id_clr), 1);
    chk("rd_id_ex_clr", int'(bus.id_ex_clr), 1);
    tick();
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("rd_stall_same", int'(stall_cnt), s0);
    chk("rd_flush_inc", int'(flush_cnt), f0 + 1);
`endif
    idle();

    // dm_busy holds off a redirect for 3 cycles
    for (int i = 0; i < 3; i++) begin
      bus.dm_busy = 1; bus.ex_redirect = 1;
      #1;
      chk("busy_pc_we", int'(bus.pc_we), 0);
      chk("busy_ex_mem_we", int'(bus.ex_mem_we), 0);
      chk("busy_mem_wb_we", int'(bus.mem_wb_we), 1);
      chk("busy_mem_wb_clr", int'(bus.mem_wb_clr), 1);
      chk("busy_if_id_clr", int'(bus.if_id_clr), 0);
      tick();
    end
    bus.dm_busy = 0;
    #1;
    chk("busy_end_pc_we", int'(bus.pc_we), 1);
    chk("busy_end_if_id_clr", int'(bus.if_id_clr), 1);
    tick();
    idle();

    // halt latency
    bus.id_halt = 1;
    #1;
    chk("halt_pc_we", int'(bus.pc_we), 0);
    chk("halt_id_ex_clr", int'(bus.id_ex_clr), 1);
    tick();
    bus.id_halt = 0;
    n = 0;
    while (!bus.hlt && n < 20) begin
      tick();
      n++;
    end
    chk("halt_latency", n, DC);
    #1;
    chk("halted_pc_we", int'(bus.pc_we), 0);
    chk("halted_id_ex_clr", int'(bus.id_ex_clr), 0);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst_halt_hlt", int'(bus.hlt), 0);
    chk("rst_halt_pc_we", int'(bus.pc_we), 1);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("rst_halt_stall", int'(stall_cnt), 0);
    chk("rst_halt_flush", int'(flush_cnt), 0);
`endif
    tick();

    // halt with one busy cycle during drain
    bus.id_halt = 1;
    tick();
    bus.id_halt = 0;
    n = 0;
    while (!bus.hlt && n < 20) begin
      bus.dm_busy = (n == 1);
      tick();
      n++;
    end
    bus.dm_busy = 0;
    chk("halt_busy_latency", n, DC + 1);
    rst = 1;
    tick();
    rst = 0;

    // random phase
    for (int c = 0; c < 3000; c++) begin
      if (m_mode == 2) rst = ($urandom % 4) == 0;
      else rst = ($urandom % 300) == 0;
      bus.dm_busy = ($urandom % 5) == 0;
      bus.ex_redirect = (m_mode != 1) && (($urandom % 6) == 0);
      bus.ex_mem_rd = $urandom % 2;
      bus.ex_reg_wrt = ($urandom % 4) != 0;
      bus.ex_wb_dst = AW'($urandom % 4);
      bus.id_rs1 = AW'($urandom % 4);
      bus.id_rs2 = AW'($urandom % 4);
      bus.id_rs1_used = $urandom % 2;
      bus.id_rs2_used = $urandom % 2;
      bus.id_halt = ($urandom % 25) == 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline control unit for the 5-stage WISC-15 core.
- Generates per-stage write enables and clears for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, flushes wrong-path instructions on EX-resolved redirects (branch/call/ret), and freezes the pipe while data memory is busy.
- Sequences halt: stops fetch, drains in-flight instructions, then asserts hlt. mem_wb_clr drives the MEM/WB clear input.

Parameters:
- DRAIN_CYCLES, 4, cycles after halt leaves ID before hlt asserts; legal 1..15.
- REG_AW, 4, register address width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_rs1  in  REG_AW  ID-stage source register 1
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2  in  REG_AW  ID-stage source register 2
- id_rs2_used  in  1  ID instruction reads rs2
- id_halt  in  1  ID instruction is HLT
- ex_wb_dst  in  REG_AW  EX-stage destination register
- ex_reg_wrt  in  1  EX instruction writes the register file
- ex_mem_rd  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved a taken branch/call/ret; PC mux selects target
- dm_busy  in  1  data memory not ready this cycle
- pc_we  out  1  PC load enable
- if_id_we  out  1  IF/ID load enable
- if_id_clr  out  1  IF/ID clear to NOP (wins over we)
- id_ex_we  out  1  ID/EX load enable
- id_ex_clr  out  1  ID/EX clear to NOP (wins over we)
- ex_mem_we  out  1  EX/MEM load enable
- mem_wb_we  out  1  MEM/WB load enable
- mem_wb_clr  out  1  MEM/WB clear (bubble into WB)
- hlt  out  1  core halted; registered

Behaviour:
- Enable and clear outputs are combinational from state and inputs. hlt, state and drain counter are registered.
- Reset (rst=1 at posedge): state<=RUN, cnt<=0, hlt<=0.
- While rst is high, all we=0 and all clr=1.
- States: RUN, DRAIN, HALTED.
- Default in RUN with no event: all we=1, all clr=0.
- load_use = ex_mem_rd & ex_reg_wrt & (ex_wb_dst!=0) & ((id_rs1_used & id_rs1==ex_wb_dst) | (id_rs2_used & id_rs2==ex_wb_dst)). R0 never hazards.
- RUN priority, highest first:
  1. dm_busy: pc_we=if_id_we=id_ex_we=ex_mem_we=0, mem_wb_clr=1, other clr=0. All other events are ignored this cycle and re-evaluated next cycle.
  2. ex_redirect: pc_we=1, if_id_clr=1, id_ex_clr=1, others default. A coincident load_use or id_halt is discarded because it is wrong-path.
  3. load_use: pc_we=0, if_id_we=0, id_ex_clr=1, others default. Exactly one bubble per hazard.
  4. id_halt: pc_we=0, if_id_we=0, id_ex_clr=1. Next state DRAIN, cnt<=DRAIN_CYCLES-1.
- DRAIN:
  - pc_we=0, if_id_we=0, id_ex_clr=1; EX/MEM and MEM/WB advance.
  - cnt decrements each cycle dm_busy=0. dm_busy applies the same freeze as RUN (cnt holds).
  - cnt==0 and !dm_busy: next HALTED, hlt<=1.
  - ex_redirect is ignored (cannot occur, since older instructions are past EX); the bench asserts on it.
- HALTED: all we=0, all clr=0, hlt=1. Only rst exits.
- Reset mid-DRAIN or in HALTED returns to RUN next cycle with hlt=0.
- DRAIN_CYCLES=1: HALTED is entered one cycle after halt leaves ID.

Optional Feature:
- Macro PIPE_HAZARD_PERF_CNT_EN.
- When defined, adds outputs:
  - stall_cnt[15:0]: increments on each RUN cycle with load_use or dm_busy.
  - flush_cnt[15:0]: increments on each RUN cycle with ex_redirect and !dm_busy.
- Both counters saturate at 16'hFFFF, clear on rst, and freeze in DRAIN/HALTED.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: ex_mem_rd=1, ex_reg_wrt=1, ex_wb_dst=3, id_rs1=3, id_rs1_used=1 -> one cycle with pc_we=0, if_id_we=0, id_ex_clr=1; next cycle (ex_mem_rd=0) all we=1.
- R0/unused: same as above but ex_wb_dst=0, or id_rs1_used=0 -> no stall; pc_we=1, id_ex_clr=0.
- Redirect + load_use together -> pc_we=1, if_id_clr=1, id_ex_clr=1, no stall; stall_cnt unchanged and flush_cnt+1 (with PIPE_HAZARD_PERF_CNT_EN).
- dm_busy for 3 cycles with ex_redirect=1 -> 3 cycles of all we=0 except mem_wb_we, mem_wb_clr=1; redirect takes effect on the 4th cycle.
- Halt, DRAIN_CYCLES=4: id_halt pulse -> pc_we=0 from that cycle, hlt=1 exactly 4 cycles later; one dm_busy cycle inserted during DRAIN -> hlt delayed to 5 cycles.
- rst asserted in HALTED -> next cycle hlt=0, state RUN, pc_we=1, counters 0.
